cache_bus_arbiter: RTL and testbench
====================================

Name: cache_bus_arbiter

Overview:
- Shares the single RAM port between the icache and dcache of NCPU cores.
- Sits between per-core cache blocks (iREN/dREN/dWEN request sides) and the RAM model.
- Grants exactly one requester at a time and holds the grant for a whole multi-word dcache refill or writeback.
- Drives RAM strobes from the granted requester; returns wait/load to all requesters.

Parameters:
NCPU, 2, number of cores (each has one icache + one dcache requester)
WORD_W, 32, data/address width

Ports:
clk  in  1  clock
nRST  in  1  asynchronous active-low reset
iREN  in  NCPU  icache read request per core
iaddr  in  NCPU*WORD_W  icache address per core
iwait  out  NCPU  icache stall per core
iload  out  NCPU*WORD_W  icache read data per core
dREN  in  NCPU  dcache read request per core
dWEN  in  NCPU  dcache write request per core
daddr  in  NCPU*WORD_W  dcache address per core
dstore  in  NCPU*WORD_W  dcache write data per core
dwait  out  NCPU  dcache stall per core
dload  out  NCPU*WORD_W  dcache read data per core
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  0=FREE 1=BUSY 2=ACCESS 3=ERROR
bus_err  out  1  sticky: ERROR seen while granted

Behaviour:
- Reset (nRST low, async): state IDLE, rr pointer 0, grant none, bus_err 0. All RAM strobes, ramaddr and ramstore are 0. iwait/dwait are all 1. iload/dload are 0.
- States: IDLE, SERVE.
- IDLE:
  - No RAM strobes. All waits 1.
  - Arbitrate on registered compare. dcache requests (dREN|dWEN) beat icache requests.
  - Within a class, round-robin across cores starting at the rr pointer.
  - On any request: latch the grant (class, core id) and go to SERVE next cycle. Minimum latency from request to first RAM strobe is 1 cycle.
- SERVE:
  - ramaddr/ramstore/strobes come combinationally from the granted requester.
  - dWEN and dREN both high: write wins (ramWEN=1, ramREN=0).
  - Granted wait = !(ramstate==ACCESS). The granted load output = ramload when ramstate==ACCESS, else 0.
  - Every non-granted wait = 1.
- Release:
  - The grant is held while the granted requester keeps its request asserted. A 2-word dcache refill/writeback therefore completes without interleaving.
  - When the granted request drops: return to IDLE, and set the rr pointer to (granted core + 1) mod NCPU.
  - There is one dead cycle between grants.
- ERROR in SERVE: treated as a stall (wait stays 1). bus_err is set and held until reset.
- A request that drops in the same cycle as grant latching: SERVE sees no request and returns to IDLE after 1 cycle. No RAM strobe is issued.
- A requester changing daddr mid-grant is followed combinationally; the arbiter does not latch addresses.
- Starvation: because of the round-robin rotation, each core's dcache waits at most NCPU-1 dcache grants. icache waits only while dcache requests are pending; this is acceptable.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds output ports grant_cnt (NCPU*2*32; per requester, index core*2+{0=i,1=d}) and stall_cnt (32).
  - grant_cnt increments on each IDLE->SERVE grant to that requester.
  - stall_cnt increments every cycle any request is pending while not ACCESS.
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR)
  - arb_state_t (IDLE, SERVE)
  - req_class_t (ICLASS, DCLASS)
  - word_t from cpu_types_pkg
- One natural sub-module: rr_picker. It is a combinational round-robin one-hot select given a request vector and pointer, and is instanced once per class.

Test Plan:
- Reset mid-SERVE with ramstate=ACCESS -> next cycle ramREN=0, all waits 1, bus_err 0, rr pointer 0.
- Core0 iREN + core1 dREN same cycle, addr 0x100 / 0x200 -> core1 dcache granted, ramaddr=0x200 in SERVE; core0 iwait=1 until core1 dREN drops; core0 granted 2 cycles later.
- Core0 dcache 2-word refill (0x40, 0x44), ramstate ACCESS every 2nd cycle; core1 dREN asserted throughout -> no interleave, core1 granted only after core0 dREN drops.
- Both cores dREN held continuously with repeated drop/reassert -> grants alternate 0,1,0,1.
- dREN=dWEN=1, dstore=0xDEADBEEF, daddr=0x80 -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- ramstate=ERROR during grant -> wait stays 1, bus_err=1 and stays 1 after a later ACCESS (with ARB_STATS_EN: stall_cnt counts those cycles).

Source files
------------

// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types for the cache bus arbiter: RAM handshake states, the
// arbiter FSM states, the requester class and a saturating counter helper.
package cache_bus_arbiter_pkg;

    typedef logic [31:0] word_t;

    localparam word_t WORD_MAX = '1;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    typedef enum logic {
        ICLASS = 1'b0,
        DCLASS = 1'b1
    } req_class_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic word_t sat_inc(input word_t value);
        return (value == WORD_MAX) ? value : value + word_t'(1);
    endfunction

endpackage

// File: rtl/cache_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// asserted request found when scanning upward from ptr, wrapping at NCPU.
module cache_bus_arbiter_rr_picker #(
    parameter int NCPU = 2,
    parameter int PW   = 1
) (
    input  logic [NCPU-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NCPU-1:0] gnt
);

    // Scan NCPU slots starting at ptr and keep only the first hit.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves it unassigned (no latch).
        gnt = '0;
        for (int off = 0; off < NCPU; off++) begin
            int slot;
            slot = int'(ptr) + off;
            if (slot >= NCPU) begin
                slot = slot - NCPU;
            end
            for (int k = 0; k < NCPU; k++) begin
                if (gnt == '0 && k == slot && req[k]) begin
                    gnt[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Cache bus arbiter: shares one RAM port between the icache and dcache of
// NCPU cores. dcache beats icache, round-robin within a class, and a grant
// is held until the granted requester drops its request.
// Optional per-requester grant and stall counters: define ARB_STATS_EN.
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int NCPU   = 2,
    parameter int WORD_W = 32
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic [NCPU-1:0]        iREN,
    input  logic [NCPU*WORD_W-1:0] iaddr,
    output logic [NCPU-1:0]        iwait,
    output logic [NCPU*WORD_W-1:0] iload,
    input  logic [NCPU-1:0]        dREN,
    input  logic [NCPU-1:0]        dWEN,
    input  logic [NCPU*WORD_W-1:0] daddr,
    input  logic [NCPU*WORD_W-1:0] dstore,
    output logic [NCPU-1:0]        dwait,
    output logic [NCPU*WORD_W-1:0] dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic [1:0]             ramstate,
    output logic                   bus_err
`ifdef ARB_STATS_EN
    ,
    output logic [NCPU*2*32-1:0]   grant_cnt,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int PW = (NCPU > 1) ? $clog2(NCPU) : 1;

    arb_state_t state, state_n;
    req_class_t gnt_cls, gnt_cls_n;
    logic [PW-1:0] gnt_core, gnt_core_n;
    logic [PW-1:0] rr_ptr, rr_ptr_n;
    logic [PW-1:0] d_idx, i_idx;
    logic [NCPU-1:0] dreq, d_pick, i_pick;
    logic gnt_req;
    ramstate_t rs;

    assign rs   = ramstate_t'(ramstate);
    assign dreq = dREN | dWEN;

    cache_bus_arbiter_rr_picker #(.NCPU(NCPU), .PW(PW)) u_dpick (
        .req(dreq),
        .ptr(rr_ptr),
        .gnt(d_pick)
    );

    cache_bus_arbiter_rr_picker #(.NCPU(NCPU), .PW(PW)) u_ipick (
        .req(iREN),
        .ptr(rr_ptr),
        .gnt(i_pick)
    );

    // Encode the one-hot picks and look up whether the granted request is still up.
    always_comb begin
        d_idx   = '0;
        i_idx   = '0;
        gnt_req = 1'b0;
        for (int k = 0; k < NCPU; k++) begin
            if (d_pick[k]) d_idx = PW'(k);
            if (i_pick[k]) i_idx = PW'(k);
            if (gnt_core == PW'(k)) begin
                gnt_req = (gnt_cls == DCLASS) ? dreq[k] : iREN[k];
            end
        end
    end

    // Next state: latch a grant from IDLE, release it when the owner drops.
    always_comb begin
        state_n    = state;
        gnt_cls_n  = gnt_cls;
        gnt_core_n = gnt_core;
        rr_ptr_n   = rr_ptr;
        case (state)
            IDLE: begin
                if (|dreq) begin
                    gnt_cls_n  = DCLASS;
                    gnt_core_n = d_idx;
                    state_n    = SERVE;
                end else if (|iREN) begin
                    gnt_cls_n  = ICLASS;
                    gnt_core_n = i_idx;
                    state_n    = SERVE;
                end
            end
            SERVE: begin
                if (!gnt_req) begin
                    state_n  = IDLE;
                    rr_ptr_n = (gnt_core == PW'(NCPU - 1)) ? '0 : gnt_core + PW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Route the granted requester to the RAM port and RAM status back to it.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        if (state == SERVE) begin
            for (int k = 0; k < NCPU; k++) begin
                if (gnt_core == PW'(k)) begin
                    if (gnt_cls == DCLASS) begin
                        // Write wins when a dcache raises both strobes.
                        ramWEN   = dWEN[k];
                        ramREN   = dREN[k] & ~dWEN[k];
                        ramaddr  = daddr[k*WORD_W +: WORD_W];
                        ramstore = dstore[k*WORD_W +: WORD_W];
                        dwait[k] = (rs != ACCESS);
                        if (rs == ACCESS) dload[k*WORD_W +: WORD_W] = ramload;
                    end else begin
                        ramREN   = iREN[k];
                        ramaddr  = iaddr[k*WORD_W +: WORD_W];
                        iwait[k] = (rs != ACCESS);
                        if (rs == ACCESS) iload[k*WORD_W +: WORD_W] = ramload;
                    end
                end
            end
        end
    end

    // State, grant, round-robin pointer and sticky error registers.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            gnt_cls  <= ICLASS;
            gnt_core <= '0;
            rr_ptr   <= '0;
            bus_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state    <= state_n;
            gnt_cls  <= gnt_cls_n;
            gnt_core <= gnt_core_n;
            rr_ptr   <= rr_ptr_n;
            if (state == SERVE && rs == ERROR) bus_err <= 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    word_t grant_q [NCPU*2];
    word_t stall_q;
    logic  grant_evt;
    logic  pending;

    assign grant_evt = (state == IDLE) && (state_n == SERVE);
    assign pending   = (|iREN) || (|dreq);

    // Saturating grant counters per requester and a global stall counter.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            // NOTE: the counter array is a handful of flops, not RAM, so it is reset like any register.
            for (int g = 0; g < NCPU*2; g++) grant_q[g] <= '0;
            stall_q <= '0;
        end else begin
            for (int g = 0; g < NCPU*2; g++) begin
                if (grant_evt && gnt_core_n == PW'(g / 2) &&
                    gnt_cls_n == (((g % 2) != 0) ? DCLASS : ICLASS)) begin
                    grant_q[g] <= sat_inc(grant_q[g]);
                end
            end
            if (pending && rs != ACCESS) stall_q <= sat_inc(stall_q);
        end
    end

    for (genvar g = 0; g < NCPU*2; g++) begin : g_gcnt
        assign grant_cnt[g*32 +: 32] = grant_q[g];
    end
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed scenario tasks plus a
// background reference model compared against every output each cycle.
module tb_cache_bus_arbiter;

    localparam int NCPU = 2;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              nRST = 1'b0;
    logic [NCPU-1:0]   iREN = '0;
    logic [NCPU*W-1:0] iaddr = '0;
    logic [NCPU-1:0]   iwait;
    logic [NCPU*W-1:0] iload;
    logic [NCPU-1:0]   dREN = '0;
    logic [NCPU-1:0]   dWEN = '0;
    logic [NCPU*W-1:0] daddr = '0;
    logic [NCPU*W-1:0] dstore = '0;
    logic [NCPU-1:0]   dwait;
    logic [NCPU*W-1:0] dload;
    logic              ramREN, ramWEN;
    logic [W-1:0]      ramaddr, ramstore;
    logic [W-1:0]      ramload = '0;
    logic [1:0]        ramstate = 2'd0;
    logic              bus_err;
`ifdef ARB_STATS_EN
    logic [NCPU*2*32-1:0] grant_cnt;
    logic [31:0]          stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    cache_bus_arbiter #(.NCPU(NCPU), .WORD_W(W)) dut (
        .clk(clk), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
`ifdef ARB_STATS_EN
        , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Owner of the bus (if any), next core to favour, sticky error, counters.
    bit          m_own  = 1'b0;
    bit          m_cls  = 1'b0;   // 1 = dcache
    int          m_core = 0;
    int          m_rr   = 0;
    bit          m_err  = 1'b0;
    logic [31:0] m_gcnt [NCPU*2];
    logic [31:0] m_stall = '0;

    always @(posedge clk or negedge nRST) begin : model
        int  pick;
        bit  pcls;
        bit  still;
        bit  anyreq;
        if (!nRST) begin
            m_own   <= 1'b0;
            m_cls   <= 1'b0;
            m_core  <= 0;
            m_rr    <= 0;
            m_err   <= 1'b0;
            m_stall <= '0;
            for (int g = 0; g < NCPU*2; g++) m_gcnt[g] <= '0;
        end else begin
            anyreq = (iREN != '0) || ((dREN | dWEN) != '0);
            if (anyreq && ramstate != 2'd2 && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 1;
            if (!m_own) begin
                pick = -1;
                pcls = 1'b0;
                for (int k = 0; k < NCPU; k++) begin
                    int c;
                    c = (m_rr + k) % NCPU;
                    if (pick < 0 && (dREN[c] || dWEN[c])) begin
                        pick = c;
                        pcls = 1'b1;
                    end
                end
                for (int k = 0; k < NCPU; k++) begin
                    int c;
                    c = (m_rr + k) % NCPU;
                    if (pick < 0 && iREN[c]) pick = c;
                end
                if (pick >= 0) begin
                    m_own  <= 1'b1;
                    m_cls  <= pcls;
                    m_core <= pick;
                    if (m_gcnt[pick*2 + int'(pcls)] != 32'hFFFF_FFFF)
                        m_gcnt[pick*2 + int'(pcls)] <= m_gcnt[pick*2 + int'(pcls)] + 1;
                end
            end else begin
                if (ramstate == 2'd3) m_err <= 1'b1;
                still = m_cls ? (dREN[m_core] || dWEN[m_core]) : iREN[m_core];
                if (!still) begin
                    m_own <= 1'b0;
                    m_rr  <= (m_core + 1) % NCPU;
                end
            end
        end
    end

    // Compare every output against the model half a cycle after the edge.
    always @(negedge clk) begin : monitor
        logic [NCPU-1:0]   e_iw, e_dw;
        logic [NCPU*W-1:0] e_il, e_dl;
        logic              e_ren, e_wen;
        logic [W-1:0]      e_addr, e_st;
        bit                acc;
        e_iw = '1; e_dw = '1; e_il = '0; e_dl = '0;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_st = '0;
        acc = (ramstate == 2'd2);
        if (nRST && m_own) begin
            if (m_cls) begin
                e_wen  = dWEN[m_core];
                e_ren  = dREN[m_core] && !dWEN[m_core];
                e_addr = daddr[m_core*W +: W];
                e_st   = dstore[m_core*W +: W];
                e_dw[m_core] = !acc;
                if (acc) e_dl[m_core*W +: W] = ramload;
            end else begin
                e_ren  = iREN[m_core];
                e_addr = iaddr[m_core*W +: W];
                e_iw[m_core] = !acc;
                if (acc) e_il[m_core*W +: W] = ramload;
            end
        end
        total++; if ({ramREN, ramWEN} !== {e_ren, e_wen}) begin bad++; $display("FAIL mon_strobe t=%0t got=%b exp=%b", $time, {ramREN, ramWEN}, {e_ren, e_wen}); end
        total++; if (ramaddr !== e_addr) begin bad++; $display("FAIL mon_addr t=%0t got=%h exp=%h", $time, ramaddr, e_addr); end
        total++; if (ramstore !== e_st) begin bad++; $display("FAIL mon_store t=%0t got=%h exp=%h", $time, ramstore, e_st); end
        total++; if (iwait !== e_iw) begin bad++; $display("FAIL mon_iwait t=%0t got=%b exp=%b", $time, iwait, e_iw); end
        total++; if (dwait !== e_dw) begin bad++; $display("FAIL mon_dwait t=%0t got=%b exp=%b", $time, dwait, e_dw); end
        total++; if (iload !== e_il) begin bad++; $display("FAIL mon_iload t=%0t got=%h exp=%h", $time, iload, e_il); end
        total++; if (dload !== e_dl) begin bad++; $display("FAIL mon_dload t=%0t got=%h exp=%h", $time, dload, e_dl); end
        total++; if (bus_err !== (nRST ? m_err : 1'b0)) begin bad++; $display("FAIL mon_bus_err t=%0t got=%b exp=%b", $time, bus_err, m_err); end
`ifdef ARB_STATS_EN
        for (int g = 0; g < NCPU*2; g++) begin
            total++; if (grant_cnt[g*32 +: 32] !== m_gcnt[g]) begin bad++; $display("FAIL mon_grant_cnt[%0d] got=%0d exp=%0d", g, grant_cnt[g*32 +: 32], m_gcnt[g]); end
        end
        total++; if (stall_cnt !== m_stall) begin bad++; $display("FAIL mon_stall_cnt got=%0d exp=%0d", stall_cnt, m_stall); end
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = 2'd0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        tick();
        tick();
        nRST = 1'b1;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        do_reset();
        ramstate = 2'd2; dREN[0] = 1'b1; daddr[0*W +: W] = 32'h10;
        tick();                                  // SERVE core0 dcache
        ramstate = 2'd3;
        tick();                                  // ERROR seen while granted
        total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL rst_pre_err got=%b exp=1", bus_err); end
        dREN[0] = 1'b0; ramstate = 2'd2;
        tick();                                  // release, rr moves to core1
        dREN[0] = 1'b1;
        tick();                                  // core0 granted again
        total++; if (ramREN !== 1'b1 || dwait[0] !== 1'b0) begin bad++; $display("FAIL rst_pre_serve got=%b%b exp=10", ramREN, dwait[0]); end
        #2 nRST = 1'b0;
        #1;
        total++; if (ramREN !== 1'b0) begin bad++; $display("FAIL rst_ramren got=%b exp=0", ramREN); end
        total++; if (iwait !== '1 || dwait !== '1) begin bad++; $display("FAIL rst_waits got=%b/%b exp=11/11", iwait, dwait); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL rst_bus_err got=%b exp=0", bus_err); end
        total++; if (ramaddr !== '0 || dload !== '0) begin bad++; $display("FAIL rst_addr_load got=%h/%h exp=0", ramaddr, dload); end
        dREN[1] = 1'b1; daddr[1*W +: W] = 32'h20;
        tick();
        nRST = 1'b1;
        tick();                                  // rr back at 0: core0 must win
        total++; if (ramaddr !== 32'h10) begin bad++; $display("FAIL rst_rr_ptr got=%h exp=%h", ramaddr, 32'h10); end
        clear_inputs();
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        ramstate = 2'd2;
        iREN[0] = 1'b1; iaddr[0*W +: W] = 32'h100;
        dREN[1] = 1'b1; daddr[1*W +: W] = 32'h200;
        tick();
        total++; if (ramaddr !== 32'h200 || ramREN !== 1'b1) begin bad++; $display("FAIL prio_dgrant got=%h/%b exp=200/1", ramaddr, ramREN); end
        for (int i = 0; i < 3; i++) begin
            total++; if (iwait[0] !== 1'b1) begin bad++; $display("FAIL prio_iwait got=%b exp=1", iwait[0]); end
            tick();
        end
        dREN[1] = 1'b0;
        tick();                                  // dead cycle
        total++; if (iwait[0] !== 1'b1 || ramREN !== 1'b0) begin bad++; $display("FAIL prio_dead got=%b/%b exp=1/0", iwait[0], ramREN); end
        tick();
        total++; if (ramaddr !== 32'h100 || iwait[0] !== 1'b0) begin bad++; $display("FAIL prio_igrant got=%h/%b exp=100/0", ramaddr, iwait[0]); end
        clear_inputs();
        tick();
    endtask

    task automatic test_refill();
        int words;
        do_reset();
        ramstate = 2'd1;
        dREN = 2'b11;
        daddr[0*W +: W] = 32'h40;
        daddr[1*W +: W] = 32'h300;
        tick();
        words = 0;
        for (int i = 0; i < 12 && words < 2; i++) begin
            ramstate = (i % 2 == 1) ? 2'd2 : 2'd1;
            #1;
            total++; if (ramaddr !== ((words == 0) ? 32'h40 : 32'h44)) begin bad++; $display("FAIL refill_addr got=%h word=%0d", ramaddr, words); end
            total++; if (dwait[1] !== 1'b1) begin bad++; $display("FAIL refill_core1_wait got=%b exp=1", dwait[1]); end
            if (ramstate == 2'd2) begin
                words++;
                if (words == 1) daddr[0*W +: W] = 32'h44;
                else dREN[0] = 1'b0;
            end
            tick();
        end
        total++; if (words !== 2) begin bad++; $display("FAIL refill_timeout got=%0d exp=2", words); end
        ramstate = 2'd2;
        #1;
        total++; if (ramREN !== 1'b0 || dwait[1] !== 1'b1) begin bad++; $display("FAIL refill_dead got=%b/%b exp=0/1", ramREN, dwait[1]); end
        tick();
        total++; if (ramaddr !== 32'h300 || dwait[1] !== 1'b0) begin bad++; $display("FAIL refill_core1 got=%h/%b exp=300/0", ramaddr, dwait[1]); end
        clear_inputs();
        tick();
    endtask

    task automatic test_alternate();
        do_reset();
        ramstate = 2'd2;
        dREN = 2'b11;
        daddr[0*W +: W] = 32'h1000;
        daddr[1*W +: W] = 32'h2000;
        for (int k = 0; k < 4; k++) begin
            bit found;
            int g;
            found = 1'b0;
            for (int t = 0; t < 10 && !found; t++) begin
                if (ramREN) found = 1'b1;
                else tick();
            end
            g = (ramaddr == 32'h2000) ? 1 : 0;
            total++; if (!found || g != k % 2) begin bad++; $display("FAIL alt_grant%0d got=%0d found=%b exp=%0d", k, g, found, k % 2); end
            dREN[g] = 1'b0;
            tick();
            dREN[g] = 1'b1;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_write_wins();
        do_reset();
        ramstate = 2'd2;
        dREN[0] = 1'b1; dWEN[0] = 1'b1;
        daddr[0*W +: W] = 32'h80; dstore[0*W +: W] = 32'hDEAD_BEEF;
        tick();
        total++; if ({ramWEN, ramREN} !== 2'b10) begin bad++; $display("FAIL wr_strobes got=%b exp=10", {ramWEN, ramREN}); end
        total++; if (ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h80) begin bad++; $display("FAIL wr_data got=%h@%h exp=deadbeef@80", ramstore, ramaddr); end
        clear_inputs();
        tick();
    endtask

    task automatic test_drop_at_grant();
        do_reset();
        ramstate = 2'd2;
        iREN[1] = 1'b1; iaddr[1*W +: W] = 32'h500;
        tick();                                  // grant latched
        iREN[1] = 1'b0;
        #1;
        total++; if ({ramREN, ramWEN} !== 2'b00) begin bad++; $display("FAIL drop_strobe got=%b exp=00", {ramREN, ramWEN}); end
        tick();
        total++; if (ramREN !== 1'b0 || iwait !== '1) begin bad++; $display("FAIL drop_idle got=%b/%b exp=0/11", ramREN, iwait); end
        tick();
    endtask

    task automatic test_error();
        do_reset();
        ramstate = 2'd3;
        dREN[1] = 1'b1; daddr[1*W +: W] = 32'h900;
        tick();
        total++; if (dwait[1] !== 1'b1) begin bad++; $display("FAIL err_wait got=%b exp=1", dwait[1]); end
        tick();
        total++; if (bus_err !== 1'b1 || dwait[1] !== 1'b1) begin bad++; $display("FAIL err_set got=%b/%b exp=1/1", bus_err, dwait[1]); end
        ramstate = 2'd2; ramload = 32'h1234_5678;
        #1;
        total++; if (dwait[1] !== 1'b0 || dload[1*W +: W] !== 32'h1234_5678) begin bad++; $display("FAIL err_access got=%b/%h", dwait[1], dload[1*W +: W]); end
        tick();
        tick();
        total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bus_err); end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 800; n++) begin
            int r;
            for (int c = 0; c < NCPU; c++) begin
                if ($urandom_range(3) == 0) iREN[c] = ~iREN[c];
                if ($urandom_range(3) == 0) dREN[c] = ~dREN[c];
                if ($urandom_range(7) == 0) dWEN[c] = ~dWEN[c];
                if ($urandom_range(3) == 0) iaddr[c*W +: W] = $urandom;
                if ($urandom_range(3) == 0) daddr[c*W +: W] = $urandom;
                if ($urandom_range(3) == 0) dstore[c*W +: W] = $urandom;
            end
            r = $urandom_range(19);
            ramstate = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
            ramload = $urandom;
            if (n == 400) begin
                nRST = 1'b0;
                #1 nRST = 1'b1;
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_refill();
        test_alternate();
        test_write_wins();
        test_drop_at_grant();
        test_error();
        test_random();
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
